tick_counter: RTL and testbench

- Downstream consumer of the free-running clock-generator pulse outputs (periods of 2, 3, 5 and 10 time units, with high times of 1 or 2).
- Synchronises one generator pulse train into the system clock domain and detects its rising edges.
- Counts the detected edges with a WIDTH-bit up/down counter; the default is the 2-bit counter of this design.
- Supports parallel load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.

---
 rtl/tick_counter_if.sv | 40 ++++
 rtl/tick_counter.sv | 123 ++++++++++++
 tb/tb_tick_counter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/tick_counter_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tick_counter_if
// Bundles the tick input, the counter controls and the counter status
// outputs of tick_counter. Signal prefixes are from the counter's view:
// i_* flows into the counter and o_* flows out of it.
//   i_tick_in   : asynchronous pulse from a clock-generator output
//   i_en        : counting enable
//   i_up_dn     : 1 = count up, 0 = count down
//   i_load      : synchronous parallel load strobe
//   i_load_val  : value placed in the count on load
//   o_count     : registered count
//   o_tick_seen : one-cycle pulse per detected rising edge of i_tick_in
//   o_tc        : one-cycle terminal-count pulse
//   o_ovf       : sticky terminal-event flag
// Modports: slave = the counter, master = whoever drives it.
// ----------------------------------------------------------------------------
interface tick_counter_if #(
    parameter int WIDTH = 2
) ();
    logic             i_tick_in;
    logic             i_en;
    logic             i_up_dn;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic [WIDTH-1:0] o_count;
    logic             o_tick_seen;
    logic             o_tc;
    logic             o_ovf;

    modport slave (
        input  i_tick_in, i_en, i_up_dn, i_load, i_load_val,
        output o_count, o_tick_seen, o_tc, o_ovf
    );

    modport master (
        output i_tick_in, i_en, i_up_dn, i_load, i_load_val,
        input  o_count, o_tick_seen, o_tc, o_ovf
    );
endinterface

// File: rtl/tick_counter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tick_counter
// Synchronises a free-running generator pulse train into the clk domain,
// detects its rising edges and counts them with a WIDTH-bit up/down counter
// that either wraps or saturates at its limits.
// Ports:
//   clk : system clock (faster than twice any tick high/low phase)
//   rst : synchronous, active-high reset, overrides everything
//   bus : tick_counter_if.slave, carries tick input, controls and status
// Parameters:
//   WIDTH       : counter width, 1..16
//   SYNC_STAGES : synchroniser depth on the tick input, 2..4
//   WRAP        : 1 = modulo counting, 0 = saturate at 0 / max
// Priority on each clk edge: rst > load > (edge and en) > hold.
// ----------------------------------------------------------------------------
module tick_counter #(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int WRAP        = 1
) (
    input  logic               clk,
    input  logic               rst,
    tick_counter_if.slave      bus
);

    localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1'b1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_edge;

    logic [WIDTH-1:0]       r_count;
    logic                   r_tick_seen;
    logic                   r_tc;
    logic                   r_ovf;

    logic [WIDTH-1:0]       w_count;
    logic                   w_tc;
    logic                   w_ovf;

    // Synchroniser chain and edge-history flop. Reset to all ones so that a
    // tick input already high when reset releases is not seen as an edge;
    // this also discards any tick in flight at reset time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{1'b1}};
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_tick_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Rising edge of the synchronised tick; consumed on the next clk edge.
    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Next-state logic for count, terminal pulse and sticky overflow.
    always_comb begin
        w_count = r_count;
        w_tc    = 1'b0;
        w_ovf   = r_ovf;
        if (bus.i_load) begin
            // Load wins over a coincident edge; the edge is still reported
            // through tick_seen but is not counted.
            w_count = bus.i_load_val;
            w_ovf   = 1'b0;
        end else if (w_edge && bus.i_en) begin
            if (bus.i_up_dn) begin
                if (r_count == C_MAX) begin
                    w_tc  = 1'b1;
                    w_ovf = 1'b1;
                    if (WRAP != 0) begin
                        w_count = C_ZERO;
                    end else begin
                        w_count = C_MAX;
                    end
                end else begin
                    w_count = r_count + C_ONE;
                end
            end else begin
                if (r_count == C_ZERO) begin
                    w_tc  = 1'b1;
                    w_ovf = 1'b1;
                    if (WRAP != 0) begin
                        w_count = C_MAX;
                    end else begin
                        w_count = C_ZERO;
                    end
                end else begin
                    w_count = r_count - C_ONE;
                end
            end
        end else begin
            // Hold; an edge with en low is discarded, not queued.
            w_count = r_count;
        end
    end

    // Output registers; tick_seen reports every detected edge regardless
    // of load or enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= C_ZERO;
            r_tick_seen <= 1'b0;
            r_tc        <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_count     <= w_count;
            r_tick_seen <= w_edge;
            r_tc        <= w_tc;
            r_ovf       <= w_ovf;
        end
    end

    assign bus.o_count     = r_count;
    assign bus.o_tick_seen = r_tick_seen;
    assign bus.o_tc        = r_tc;
    assign bus.o_ovf       = r_ovf;

endmodule

// File: tb/tb_tick_counter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_tick_counter
// Directed bench for tick_counter. Two instances share every input: dut_a
// uses the defaults (WRAP=1), dut_b saturates (WRAP=0). Ticks follow the
// 5-unit generator (2 high, 3 low) against a 0.5-unit clk; inputs change on
// the falling clk edge and outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_tick_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_tick;
    logic       tb_en;
    logic       tb_up_dn;
    logic       tb_load;
    logic [1:0] tb_load_val;

    int checks   = 0;
    int failures = 0;

    // Pulse tallies, sampled once per cycle on the falling edge.
    int tc_cnt_a   = 0;
    int tc_cnt_b   = 0;
    int seen_cnt_a = 0;

    // Values captured on the cycle a tick is consumed.
    logic [1:0] snap_cnt_a, snap_cnt_b;
    logic       snap_seen_a, snap_tc_a, snap_ovf_a;
    logic       snap_seen_b, snap_tc_b, snap_ovf_b;

    tick_counter_if #(.WIDTH(2)) if_a ();
    tick_counter_if #(.WIDTH(2)) if_b ();

    assign if_a.i_tick_in  = tb_tick;
    assign if_a.i_en       = tb_en;
    assign if_a.i_up_dn    = tb_up_dn;
    assign if_a.i_load     = tb_load;
    assign if_a.i_load_val = tb_load_val;
    assign if_b.i_tick_in  = tb_tick;
    assign if_b.i_en       = tb_en;
    assign if_b.i_up_dn    = tb_up_dn;
    assign if_b.i_load     = tb_load;
    assign if_b.i_load_val = tb_load_val;

    tick_counter #(.WIDTH(2), .SYNC_STAGES(2), .WRAP(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    tick_counter #(.WIDTH(2), .SYNC_STAGES(2), .WRAP(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    always #0.25 clk = ~clk;

    always @(negedge clk) begin
        tc_cnt_a   <= tc_cnt_a + int'(if_a.o_tc);
        tc_cnt_b   <= tc_cnt_b + int'(if_b.o_tc);
        seen_cnt_a <= seen_cnt_a + int'(if_a.o_tick_seen);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One generator period: tick high for 4 clks, low for 6 clks. tick rises
    // before edge k; tick_seen must stay low after k and k+1 and be high after
    // k+2. With ld=1 the load strobe is applied on edge k+2.
    task automatic do_tick(input logic ld);
        @(negedge clk);
        tb_tick = 1'b1;
        @(negedge clk);
        check("lat_k", if_a.o_tick_seen, 1'b0);
        @(negedge clk);
        check("lat_k1", if_a.o_tick_seen, 1'b0);
        if (ld) tb_load = 1'b1;
        @(negedge clk);
        tb_load     = 1'b0;
        snap_seen_a = if_a.o_tick_seen;
        snap_cnt_a  = if_a.o_count;
        snap_tc_a   = if_a.o_tc;
        snap_ovf_a  = if_a.o_ovf;
        snap_seen_b = if_b.o_tick_seen;
        snap_cnt_b  = if_b.o_count;
        snap_tc_b   = if_b.o_tc;
        snap_ovf_b  = if_b.o_ovf;
        @(negedge clk);
        check("one_shot", if_a.o_tick_seen, 1'b0);
        tb_tick = 1'b0;
        idle(6);
    endtask

    // Expected results for the five default up-count ticks.
    logic [1:0] exp_cnt2 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_tc2  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_ovf2 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_cntb [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        int tc_a0, tc_b0, seen0;

        rst         = 1'b1;
        tb_tick     = 1'b1;
        tb_en       = 1'b1;
        tb_up_dn    = 1'b1;
        tb_load     = 1'b0;
        tb_load_val = 2'd0;

        // 1: reset with tick held high, then 20 quiet cycles.
        idle(3);
        check("rst_count", if_a.o_count, 2'd0);
        check("rst_tc", if_a.o_tc, 1'b0);
        check("rst_ovf", if_a.o_ovf, 1'b0);
        check("rst_seen", if_a.o_tick_seen, 1'b0);
        seen0 = seen_cnt_a;
        rst = 1'b0;
        idle(20);
        check("hi_rel_seen", seen_cnt_a - seen0, 0);
        check("hi_rel_count", if_a.o_count, 2'd0);
        check("hi_rel_ovf", if_a.o_ovf, 1'b0);
        tb_tick = 1'b0;
        idle(6);

        // 2: five up ticks.
        tc_a0 = tc_cnt_a;
        for (int t = 0; t < 5; t++) begin
            do_tick(1'b0);
            check("up_seen", snap_seen_a, 1'b1);
            check("up_count", snap_cnt_a, exp_cnt2[t]);
            check("up_tc", snap_tc_a, exp_tc2[t]);
            check("up_ovf", snap_ovf_a, exp_ovf2[t]);
            check("sat_up_count", snap_cnt_b, exp_cntb[t]);
        end
        check("up_tc_pulses", tc_cnt_a - tc_a0, 1);

        // 3: down from 0, wrap vs saturate.
        pulse_rst();
        tb_up_dn = 1'b0;
        idle(2);
        tc_a0 = tc_cnt_a;
        tc_b0 = tc_cnt_b;
        do_tick(1'b0);
        check("dn_count_1", snap_cnt_a, 2'd3);
        check("dn_sat_count_1", snap_cnt_b, 2'd0);
        check("dn_sat_tc_1", snap_tc_b, 1'b1);
        do_tick(1'b0);
        check("dn_count_2", snap_cnt_a, 2'd2);
        check("dn_sat_count_2", snap_cnt_b, 2'd0);
        check("dn_sat_tc_2", snap_tc_b, 1'b1);
        check("dn_tc_pulses", tc_cnt_a - tc_a0, 1);
        check("dn_sat_tc_pulses", tc_cnt_b - tc_b0, 2);
        check("dn_ovf", if_a.o_ovf, 1'b1);
        check("dn_sat_ovf", if_b.o_ovf, 1'b1);

        // 4: load coincident with a detected edge.
        tb_up_dn    = 1'b1;
        tb_load_val = 2'd2;
        do_tick(1'b1);
        check("ld_count", snap_cnt_a, 2'd2);
        check("ld_seen", snap_seen_a, 1'b1);
        check("ld_tc", snap_tc_a, 1'b0);
        check("ld_ovf", snap_ovf_a, 1'b0);
        check("ld_sat_count", snap_cnt_b, 2'd2);
        check("ld_sat_ovf", snap_ovf_b, 1'b0);

        // 5: en low for three ticks from count=1, then one enabled tick.
        tb_load_val = 2'd1;
        @(negedge clk);
        tb_load = 1'b1;
        @(negedge clk);
        tb_load = 1'b0;
        check("ld1_count", if_a.o_count, 2'd1);
        tb_en = 1'b0;
        seen0 = seen_cnt_a;
        tc_a0 = tc_cnt_a;
        for (int t = 0; t < 3; t++) begin
            do_tick(1'b0);
            check("dis_seen", snap_seen_a, 1'b1);
            check("dis_count", snap_cnt_a, 2'd1);
        end
        tb_en = 1'b1;
        do_tick(1'b0);
        check("en_count", snap_cnt_a, 2'd2);
        check("en_seen_total", seen_cnt_a - seen0, 4);
        check("en_tc_pulses", tc_cnt_a - tc_a0, 0);

        // 6: reset lands while a tick is inside the synchroniser.
        seen0 = seen_cnt_a;
        @(negedge clk);
        tb_tick = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        check("flight_seen", seen_cnt_a - seen0, 0);
        check("flight_count", if_a.o_count, 2'd0);
        tb_tick = 1'b0;
        idle(6);
        do_tick(1'b0);
        check("after_rst_count", snap_cnt_a, 2'd1);
        check("after_rst_seen", snap_seen_a, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
